// File: rtl/game_status.sv
// Player-side game status: blood/score aggregation over all enemies, hit flash, IDLE/PLAY/OVER FSM.
// Optional BOXHEAD_HISCORE_EN adds a High_Score register updated on every game over.
module game_status #(
  parameter int ENEMY_NUM         = 4,
  parameter int PLAYER_FULL_BLOOD = 100,
  parameter int FLASH_FRAMES      = 8,
  parameter int WIN_SCORE         = 200
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    game_frame_clk_rising_edge,
  input  logic                    Start_Key,
  input  logic [8*ENEMY_NUM-1:0]  Enemy_Score_All,
  input  logic [10*ENEMY_NUM-1:0] Enemy_Total_Damage_All,
  output logic [6:0]              Player_Blood,
  output logic [9:0]              Total_Score,
  output logic [1:0]              Game_State,
  output logic                    Game_Won,
  output logic                    Player_Hit_Flash,
  output logic                    Game_Reset
`ifdef BOXHEAD_HISCORE_EN
  ,
  output logic [9:0]              High_Score
`endif
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] flash_cnt, flash_nxt, flash_dec;
  logic          armed, armed_nxt;
  logic [6:0]    blood_nxt, blood_new;
  logic [9:0]    score_nxt, score_sum;
  logic [11:0]   dmg_sum;
  logic          won_nxt, grst_nxt;

  always_comb begin
    score_sum = '0;
    dmg_sum   = '0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      score_sum = score_sum + 10'(Enemy_Score_All[8*i +: 8]);
      dmg_sum   = dmg_sum + 12'(Enemy_Total_Damage_All[10*i +: 10]);
    end
  end

  assign blood_new = (dmg_sum >= 12'(PLAYER_FULL_BLOOD)) ? 7'd0
                     : 7'(12'(PLAYER_FULL_BLOOD) - dmg_sum);
  assign flash_dec = (flash_cnt != '0) ? flash_cnt - 1'b1 : flash_cnt;

  always_comb begin
    state_nxt = state;
    blood_nxt = Player_Blood;
    score_nxt = Total_Score;
    won_nxt   = Game_Won;
    flash_nxt = flash_cnt;
    armed_nxt = armed;
    grst_nxt  = 1'b0;
    if (game_frame_clk_rising_edge) begin
      case (state)
        IDLE: begin
          if (Start_Key) begin
            state_nxt = PLAY;
            grst_nxt  = 1'b1;
            blood_nxt = 7'(PLAYER_FULL_BLOOD);
            score_nxt = '0;
            flash_nxt = '0;
            won_nxt   = 1'b0;
          end
        end
        PLAY: begin
          blood_nxt = blood_new;
          score_nxt = score_sum;
          flash_nxt = (blood_new < Player_Blood) ? FW'(FLASH_FRAMES) : flash_dec;
          // Death outranks a win reached in the same frame.
          if (blood_new == 7'd0) begin
            state_nxt = OVER;
            won_nxt   = 1'b0;
            armed_nxt = 1'b0;
          end else if (score_sum >= 10'(WIN_SCORE)) begin
            state_nxt = OVER;
            won_nxt   = 1'b1;
            armed_nxt = 1'b0;
          end
        end
        OVER: begin
          flash_nxt = flash_dec;
          // Key must be seen released for a frame so a held key cannot restart.
          if (Start_Key && armed) begin
            state_nxt = PLAY;
            grst_nxt  = 1'b1;
            blood_nxt = 7'(PLAYER_FULL_BLOOD);
            score_nxt = '0;
            flash_nxt = '0;
            won_nxt   = 1'b0;
          end else if (!Start_Key) begin
            armed_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      Player_Blood <= 7'(PLAYER_FULL_BLOOD);
      Total_Score  <= '0;
      Game_Won     <= 1'b0;
      flash_cnt    <= '0;
      armed        <= 1'b0;
      Game_Reset   <= 1'b0;
    end else begin
      state        <= state_nxt;
      Player_Blood <= blood_nxt;
      Total_Score  <= score_nxt;
      Game_Won     <= won_nxt;
      flash_cnt    <= flash_nxt;
      armed        <= armed_nxt;
      Game_Reset   <= grst_nxt;
    end
  end

  assign Game_State       = state;
  assign Player_Hit_Flash = (flash_cnt != '0);

`ifdef BOXHEAD_HISCORE_EN
  logic hs_load;
  assign hs_load = game_frame_clk_rising_edge && (state == PLAY) && (state_nxt == OVER);

  // Survives Game_Reset; only the system reset clears it.
  always_ff @(posedge Clk) begin
    if (Reset)
      High_Score <= '0;
    else if (hs_load && (score_sum > High_Score))
      High_Score <= score_sum;
  end
`endif

endmodule

// File: tb/tb_game_status.sv
// Randomized scoreboard bench for game_status with a frame-level reference model.
module tb_game_status;
  localparam int EN = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          game_frame_clk_rising_edge = 1'b0;
  logic          Start_Key = 1'b0;
  logic [8*EN-1:0]  Enemy_Score_All = '0;
  logic [10*EN-1:0] Enemy_Total_Damage_All = '0;
  logic [6:0]    Player_Blood;
  logic [9:0]    Total_Score;
  logic [1:0]    Game_State;
  logic          Game_Won, Player_Hit_Flash, Game_Reset;
`ifdef BOXHEAD_HISCORE_EN
  logic [9:0]    High_Score;
`endif

  game_status dut (
    .Clk(Clk), .Reset(Reset),
    .game_frame_clk_rising_edge(game_frame_clk_rising_edge),
    .Start_Key(Start_Key),
    .Enemy_Score_All(Enemy_Score_All),
    .Enemy_Total_Damage_All(Enemy_Total_Damage_All),
    .Player_Blood(Player_Blood), .Total_Score(Total_Score),
    .Game_State(Game_State), .Game_Won(Game_Won),
    .Player_Hit_Flash(Player_Hit_Flash), .Game_Reset(Game_Reset)
`ifdef BOXHEAD_HISCORE_EN
    , .High_Score(High_Score)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {int st; int blood; int score; int won; int flash; int gr; int hi;} exp_t;
  exp_t q[$];

  int n_cmp = 0, n_err = 0;
  int sc[EN], dm[EN];
  // Reference model state: game phase (0 idle,1 play,2 over), plus frame counters.
  int m_st, m_blood, m_score, m_won, m_flash, m_armed, m_hi;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic reload();
    m_st = 1; m_blood = 100; m_score = 0; m_flash = 0; m_won = 0;
  endtask

  task automatic frame(input bit start, input bit rst);
    exp_t e;
    int ssum, dsum, nb;
    @(negedge Clk);
    Start_Key = start;
    Reset = rst;
    for (int i = 0; i < EN; i++) begin
      Enemy_Score_All[8*i +: 8]         = 8'(sc[i]);
      Enemy_Total_Damage_All[10*i +: 10] = 10'(dm[i]);
    end
    game_frame_clk_rising_edge = 1'b1;
    ssum = 0; dsum = 0;
    foreach (sc[i]) begin ssum += sc[i]; dsum += dm[i]; end
    e.gr = 0;
    if (rst) begin
      m_st = 0; m_blood = 100; m_score = 0; m_won = 0; m_flash = 0; m_armed = 0; m_hi = 0;
    end else if (m_st == 0) begin
      if (start) begin reload(); e.gr = 1; end
    end else if (m_st == 1) begin
      nb = (dsum >= 100) ? 0 : 100 - dsum;
      if (nb < m_blood) m_flash = 8;
      else if (m_flash > 0) m_flash--;
      m_blood = nb;
      m_score = ssum;
      if (nb == 0 || ssum >= 200) begin
        m_st = 2; m_won = (nb == 0) ? 0 : 1; m_armed = 0;
        if (ssum > m_hi) m_hi = ssum;
      end
    end else begin
      if (m_flash > 0) m_flash--;
      if (start && m_armed == 1) begin reload(); e.gr = 1; end
      else if (!start) m_armed = 1;
    end
    e.st = m_st; e.blood = m_blood; e.score = m_score; e.won = m_won;
    e.flash = (m_flash > 0) ? 1 : 0; e.hi = m_hi;
    q.push_back(e);
    @(negedge Clk);
    game_frame_clk_rising_edge = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    // Enemy instances are cleared by the Game_Reset pulse.
    if (e.gr) foreach (sc[i]) begin sc[i] = 0; dm[i] = 0; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      if (game_frame_clk_rising_edge) begin
        #1;
        if (q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("game_state", int'(Game_State), e.st);
          chk("player_blood", int'(Player_Blood), e.blood);
          chk("total_score", int'(Total_Score), e.score);
          chk("hit_flash", int'(Player_Hit_Flash), e.flash);
          chk("game_reset", int'(Game_Reset), e.gr);
          if (e.st != 1) chk("game_won", int'(Game_Won), e.won);
`ifdef BOXHEAD_HISCORE_EN
          chk("high_score", int'(High_Score), e.hi);
`endif
          if (e.gr) begin
            @(posedge Clk); #1;
            chk("game_reset_fall", int'(Game_Reset), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit st;
    foreach (sc[i]) begin sc[i] = 0; dm[i] = 0; end
    repeat (3) @(negedge Clk);
    frame(0, 1); frame(0, 1);
    frame(0, 0); frame(0, 0);
    frame(1, 0);                                  // start
    dm[0] = 30; dm[2] = 25;
    frame(0, 0);                                  // blood 45, flash
    repeat (9) frame(0, 0);                       // flash expires
    dm[1] = 75; sc = '{70, 60, 60, 60};
    frame(0, 0);                                  // death beats win
    repeat (3) frame(1, 0);                       // held key, no restart
    frame(0, 0); frame(1, 0);                     // arm then restart
    sc[0] = 10; frame(0, 0);
    frame(0, 1);                                  // mid-game reset
    frame(1, 0);
    sc = '{60, 60, 50, 40};
    frame(0, 0);                                  // win at 210
    for (int k = 0; k < 3; k++) begin
      sc[k] += 5; dm[k] += 40; frame(0, 0);       // frozen in OVER
    end
    frame(1, 0);
    sc = '{30, 30, 30, 30}; dm[0] = 100;
    frame(0, 0);                                  // death at 120
    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      if (m_st == 1) begin
        st = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < EN; i++) begin
          if ($urandom_range(0, 3) == 0 && sc[i] < 240) sc[i] += $urandom_range(0, 4);
          if ($urandom_range(0, 3) == 0 && dm[i] < 1000) dm[i] += $urandom_range(0, 5);
        end
      end else if (m_st == 2 && $urandom_range(0, 1) == 1) begin
        sc[$urandom_range(0, EN-1)] = $urandom_range(0, 255);
        dm[$urandom_range(0, EN-1)] = $urandom_range(0, 1023);
      end
      frame(st, $urandom_range(0, 99) == 0);
    end
    frame(0, 1);
    repeat (10) @(negedge Clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
